// File: rtl/block_spi_controller_if.sv
// Bus bundle for the SPI frame controller: host-side request/response
// signals plus the four SPI pins.
interface block_spi_controller_if;
    logic        start;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        busy;
    logic        done;
    logic [15:0] rx_data;
    logic        SPI_SCK;
    logic        SPI_CS;
    logic        SPI_COPI;
    logic        SPI_CIPO;

    modport slave (
        input  start, address, data, SPI_CIPO,
        output busy, done, rx_data, SPI_SCK, SPI_CS, SPI_COPI
    );

    modport master (
        output start, address, data, SPI_CIPO,
        input  busy, done, rx_data, SPI_SCK, SPI_CS, SPI_COPI
    );
endinterface

// File: rtl/block_spi_controller.sv
// SPI mode-0 frame controller: sends {address,data} MSB first while shifting
// 16 bits in on CIPO, framed by an active-high chip select with programmable
// setup, hold and inter-frame gap.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CS low, waiting for start
// SETUP | CS high, SCK low, first bit on COPI, CS_SETUP cycles
// XFER  | 16 bits, each CLK_DIV cycles SCK low then CLK_DIV cycles high
// HOLD  | CS high, SCK low after last fall, CS_HOLD cycles
// GAP   | CS low, still busy, CS_GAP cycles before accepting a new frame
module block_spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    block_spi_controller_if.slave bus
);

    localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] DIV_LD    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LD  = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LD    = CW'(CS_GAP - 1);
    // The two-flop synchroniser delays CIPO by two cycles, so the value the
    // pin held at the SCK rise reaches cipo_sync_q two cycles into the high
    // phase; that is when it is shifted in.
    localparam logic [CW-1:0] SAMPLE_AT = CW'(CLK_DIV - 2);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bit_q, bit_d;
    logic [15:0]    tx_q, tx_d;
    logic [15:0]    shadow_q, shadow_d;
    logic [15:0]    rx_q, rx_d;
    logic           sck_q, sck_d;
    logic           cs_q, cs_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cipo_meta_q, cipo_meta_d;
    logic           cipo_sync_q, cipo_sync_d;

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        shadow_d    = shadow_q;
        rx_d        = rx_q;
        sck_d       = sck_q;
        cs_d        = cs_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cipo_meta_d = bus.SPI_CIPO;
        cipo_sync_d = cipo_meta_q;

        case (state_q)
            IDLE: begin
                cs_d   = 1'b0;
                sck_d  = 1'b0;
                busy_d = 1'b0;
                if (bus.start) begin
                    tx_d     = {bus.address, bus.data};
                    shadow_d = '0;
                    cs_d     = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = SETUP_LD;
                    state_d  = SETUP;
                end
            end

            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = DIV_LD;
                    bit_d   = 4'd15;
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            XFER: begin
                if (sck_q && cnt_q == SAMPLE_AT) begin
                    shadow_d = {shadow_q[14:0], cipo_sync_q};
                end
                if (cnt_q == '0) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        cnt_d = DIV_LD;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            cnt_d   = HOLD_LD;
                            state_d = HOLD;
                        end else begin
                            tx_d  = {tx_q[14:0], 1'b0};
                            bit_d = bit_q - 4'd1;
                            cnt_d = DIV_LD;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            HOLD: begin
                if (cnt_q == '0) begin
                    cs_d    = 1'b0;
                    done_d  = 1'b1;
                    rx_d    = shadow_q;
                    tx_d    = '0;
                    cnt_d   = GAP_LD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            GAP: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            shadow_q    <= '0;
            rx_q        <= '0;
            sck_q       <= 1'b0;
            cs_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cipo_meta_q <= 1'b0;
            cipo_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            shadow_q    <= shadow_d;
            rx_q        <= rx_d;
            sck_q       <= sck_d;
            cs_q        <= cs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cipo_meta_q <= cipo_meta_d;
            cipo_sync_q <= cipo_sync_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_data  = rx_q;
    assign bus.SPI_SCK  = sck_q;
    assign bus.SPI_CS   = cs_q;
    assign bus.SPI_COPI = tx_q[15];

endmodule

// File: tb/tb_block_spi_controller.sv
// Directed bench for block_spi_controller: a default instance and a
// CLK_DIV=2 instance, with a negedge monitor measuring frame shape.
module tb_block_spi_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic loop = 1'b0;
    logic cipo_const = 1'b0;
    logic track = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    block_spi_controller_if b0 ();
    block_spi_controller_if b1 ();

    block_spi_controller u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    block_spi_controller #(
        .CLK_DIV  (2),
        .CS_SETUP (2),
        .CS_HOLD  (2),
        .CS_GAP   (4)
    ) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    assign b0.SPI_CIPO = loop ? b0.SPI_COPI : cipo_const;
    assign b1.SPI_CIPO = b1.SPI_COPI;

    logic [1:0] cs_w, sck_w, copi_w, done_w, busy_w;
    assign cs_w   = {b1.SPI_CS,   b0.SPI_CS};
    assign sck_w  = {b1.SPI_SCK,  b0.SPI_SCK};
    assign copi_w = {b1.SPI_COPI, b0.SPI_COPI};
    assign done_w = {b1.done,     b0.done};
    assign busy_w = {b1.busy,     b0.busy};

    int          cyc = 0;
    int          cs_run [2]     = '{0, 0};
    int          cs_len [2]     = '{0, 0};
    int          rises [2]      = '{0, 0};
    int          rises_last [2] = '{0, 0};
    int          low_run [2]    = '{0, 0};
    int          low_min [2]    = '{9999, 9999};
    int          period [2]     = '{0, 0};
    int          last_rise [2]  = '{0, 0};
    int          done_cnt [2]   = '{0, 0};
    logic [15:0] copi_word [2]  = '{16'h0, 16'h0};
    logic [15:0] copi_last [2]  = '{16'h0, 16'h0};
    logic        cs_prev [2]    = '{1'b0, 1'b0};
    logic        sck_prev [2]   = '{1'b0, 1'b0};

    // Frame-shape monitor: CS high length, SCK rises, COPI at rises, gaps.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            cs_prev[i]  <= cs_w[i];
            sck_prev[i] <= sck_w[i];
            if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (!track) low_min[i] <= 9999;
            if (cs_w[i]) begin
                if (!cs_prev[i]) begin
                    cs_run[i]    <= 1;
                    rises[i]     <= 0;
                    copi_word[i] <= 16'h0;
                    if (track && low_run[i] < low_min[i]) low_min[i] <= low_run[i];
                end else begin
                    cs_run[i] <= cs_run[i] + 1;
                end
            end else begin
                if (cs_prev[i]) begin
                    cs_len[i]     <= cs_run[i];
                    rises_last[i] <= rises[i];
                    copi_last[i]  <= copi_word[i];
                    low_run[i]    <= 1;
                end else begin
                    low_run[i] <= low_run[i] + 1;
                end
            end
            if (sck_w[i] && !sck_prev[i]) begin
                rises[i]     <= rises[i] + 1;
                copi_word[i] <= {copi_word[i][14:0], copi_w[i]};
                period[i]    <= cyc - last_rise[i];
                last_rise[i] <= cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input int i, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        if (i == 0) begin
            b0.address = a; b0.data = d; b0.start = 1'b1;
        end else begin
            b1.address = a; b1.data = d; b1.start = 1'b1;
        end
        @(negedge clk);
        if (i == 0) b0.start = 1'b0;
        else        b1.start = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, input string tag);
        int n;
        n = 0;
        while (!done_w[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, done_w[i]}, 32'd1);
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        while (busy_w[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'd0, busy_w[i]}, 32'd0);
    endtask

    int k;
    int d0;
    int ndone;

    initial begin
        b0.start = 1'b0; b0.address = 8'h00; b0.data = 8'h00;
        b1.start = 1'b0; b1.address = 8'h00; b1.data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs",   {31'd0, b0.SPI_CS},   32'd0);
        chk("rst_sck",  {31'd0, b0.SPI_SCK},  32'd0);
        chk("rst_copi", {31'd0, b0.SPI_COPI}, 32'd0);
        chk("rst_busy", {31'd0, b0.busy},     32'd0);
        chk("rst_done", {31'd0, b0.done},     32'd0);
        chk("rst_rx",   {16'd0, b0.rx_data},  32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Constant CIPO=1, 0x03/0x80
        loop = 1'b0; cipo_const = 1'b1;
        d0 = done_cnt[0];
        start_frame(0, 8'h03, 8'h80);
        chk("busy_after_start", {31'd0, b0.busy}, 32'd1);
        chk("cs_after_start",   {31'd0, b0.SPI_CS}, 32'd1);
        chk("copi_first_bit",   {31'd0, b0.SPI_COPI}, 32'd0);
        wait_done(0, 300, "done_037");
        chk("rx_037", {16'd0, b0.rx_data}, 32'hFFFF);
        wait_idle(0, 20);
        @(negedge clk);
        chk("copi_037",   {16'd0, copi_last[0]}, 32'h0380);
        chk("cshigh_037", cs_len[0], 132);
        chk("rises_037",  rises_last[0], 16);
        chk("period_037", period[0], 8);
        chk("ndone_037",  done_cnt[0] - d0, 1);

        // Loopback 0xA5/0x3C, busy drops 4 cycles after done
        loop = 1'b1;
        start_frame(0, 8'hA5, 8'h3C);
        wait_done(0, 300, "done_038");
        chk("rx_038", {16'd0, b0.rx_data}, 32'hA53C);
        k = 0;
        while (b0.busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("busy_tail_038", k, 4);
        chk("copi_038", {16'd0, copi_last[0]}, 32'hA53C);

        // Start held high across three frames
        @(negedge clk);
        track = 1'b1;
        d0 = done_cnt[0];
        b0.address = 8'h5A; b0.data = 8'hC3; b0.start = 1'b1;
        ndone = 0; k = 0;
        while (ndone < 3 && k < 1000) begin
            @(negedge clk);
            k++;
            if (b0.done) ndone++;
        end
        b0.start = 1'b0;
        chk("three_done_seen", ndone, 3);
        repeat (150) @(negedge clk);
        chk("ndone_039",  done_cnt[0] - d0, 3);
        chk("gap_039",    low_min[0], 5);
        chk("cs_idle_039", {31'd0, b0.SPI_CS}, 32'd0);
        chk("rx_039", {16'd0, b0.rx_data}, 32'h5AC3);
        track = 1'b0;

        // Reset during the 7th bit high phase, then a clean frame
        start_frame(0, 8'h55, 8'hAA);
        k = 0;
        while (!(rises[0] == 7 && b0.SPI_SCK) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("bit7_high_reached", {31'd0, b0.SPI_SCK}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_cs",   {31'd0, b0.SPI_CS},   32'd0);
        chk("abort_sck",  {31'd0, b0.SPI_SCK},  32'd0);
        chk("abort_busy", {31'd0, b0.busy},     32'd0);
        chk("abort_copi", {31'd0, b0.SPI_COPI}, 32'd0);
        chk("abort_done", {31'd0, b0.done},     32'd0);
        chk("abort_rx",   {16'd0, b0.rx_data},  32'h0);
        d0 = done_cnt[0];
        reset = 1'b1;
        b0.address = 8'h01; b0.data = 8'h7F; b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        chk("start_after_reset", {31'd0, b0.busy}, 32'd1);
        wait_done(0, 300, "done_040");
        chk("rx_040", {16'd0, b0.rx_data}, 32'h017F);
        @(negedge clk);
        chk("ndone_040",  done_cnt[0] - d0, 1);
        chk("cshigh_040", cs_len[0], 132);
        wait_idle(0, 20);

        // Address/data churn while busy
        start_frame(0, 8'hC6, 8'h1B);
        k = 0;
        while (!b0.done && k < 300) begin
            b0.address = 8'($urandom);
            b0.data    = 8'($urandom);
            @(negedge clk);
            k++;
        end
        chk("done_041", {31'd0, b0.done}, 32'd1);
        chk("rx_041", {16'd0, b0.rx_data}, 32'hC61B);
        @(negedge clk);
        chk("copi_041", {16'd0, copi_last[0]}, 32'hC61B);
        wait_idle(0, 20);

        // CLK_DIV=2 instance, loopback
        start_frame(1, 8'h96, 8'h69);
        wait_done(1, 200, "done_042");
        chk("rx_042", {16'd0, b1.rx_data}, 32'h9669);
        @(negedge clk);
        chk("cshigh_042", cs_len[1], 68);
        chk("period_042", period[1], 4);
        chk("rises_042",  rises_last[1], 16);
        chk("copi_042", {16'd0, copi_last[1]}, 32'h9669);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/block_spi_controller.md
BLOCK_SPI_CONTROLLER -- requirements
Module: block_spi_controller

Interface
REQ-001 The block SHALL be clocked by one clock, and its reset SHALL be synchronous and active-low.
REQ-002 Parameter CLK_DIV, default 4: SHALL set the number of clk cycles per SCK half-period; legal range 2..255.
REQ-003 Parameter CS_SETUP, default 2: SHALL set the clk cycles from CS rise to the first SCK low phase end; minimum 1.
REQ-004 Parameter CS_HOLD, default 2: SHALL set the clk cycles from the last SCK fall to CS fall; minimum 1.
REQ-005 Parameter CS_GAP, default 4: SHALL set the minimum clk cycles CS stays low between frames; minimum 1.
REQ-006 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-007 reset  input  1  synchronous active-low reset.
REQ-008 start  input  1  request a frame; sampled only while busy=0.
REQ-009 address  input  8  frame byte 1, sent first.
REQ-010 data  input  8  frame byte 2.
REQ-011 busy  output  1  high from the cycle after an accepted start through the end of GAP.
REQ-012 done  output  1  one-cycle pulse per completed frame.
REQ-013 rx_data  output  16  word shifted in on SPI_CIPO; valid from the done cycle until the next done.
REQ-014 SPI_SCK  output  1  serial clock; idles low (mode 0).
REQ-015 SPI_CS  output  1  chip select, active high.
REQ-016 SPI_COPI  output  1  serial data out, MSB first.
REQ-017 SPI_CIPO  input  1  serial data in; the block SHALL synchronise it with 2 flops before use.

Function
REQ-018 Every output SHALL be driven from a register, with no combinational path from any input to any output.
REQ-019 FSM states SHALL be IDLE, SETUP, XFER, HOLD and GAP.
REQ-020 IDLE: CS=0, SCK=0, busy=0; on start=1 the block SHALL latch {address,data} into a 16-bit tx shift register and enter SETUP.
REQ-021 Entry to SETUP: on the next cycle CS=1, busy=1 and COPI=tx[15]; SETUP SHALL last CS_SETUP cycles and then enter XFER.
REQ-022 XFER: 16 bits; each bit SHALL be SCK low for CLK_DIV cycles and then SCK high for CLK_DIV cycles.
REQ-023 On each SCK low-to-high transition, the synchronised CIPO SHALL be shifted into rx_data's shadow register at the LSB.
REQ-024 On each SCK high-to-low transition except after the 16th bit, tx SHALL shift left and COPI SHALL take the new tx[15].
REQ-025 COPI SHALL be stable for the whole high phase and at least CLK_DIV cycles before each rise.
REQ-026 After the 16th high phase, SCK SHALL return low and the FSM SHALL enter HOLD.
REQ-027 HOLD SHALL last CS_HOLD cycles with CS=1 and SCK=0.
REQ-028 After HOLD, CS SHALL go to 0; in the same cycle done SHALL pulse, rx_data SHALL load the shadow register, and the FSM SHALL enter GAP.
REQ-029 GAP SHALL last CS_GAP cycles with busy=1 and then return to IDLE; the earliest next frame's CS rise is CS_GAP+1 cycles after CS fall.
REQ-030 With defaults, CS high time SHALL be exactly CS_SETUP+32*CLK_DIV+CS_HOLD = 132 cycles, with exactly 16 SCK rising edges.
REQ-031 A start asserted while busy=1 SHALL be ignored and not queued.
REQ-032 Changes on address and data while busy SHALL NOT affect the frame in flight.
REQ-033 Bit and phase counters SHALL be sized for 16 bits and CLK_DIV; no counter SHALL wrap inside a frame.

Reset
REQ-034 When reset=0 at a clk edge, the block SHALL force IDLE, CS=0, SCK=0, COPI=0, busy=0, done=0, rx_data=0x0000 and clear all counters, including mid-frame.
REQ-035 A frame aborted by reset SHALL NOT produce done.
REQ-036 The block SHALL accept start on the first cycle after reset returns high.

Verification
REQ-037 addr=0x03, data=0x80, CIPO=1 -> COPI sampled at the rises = 0000_0011_1000_0000; CS high 132 cycles; one done; rx_data=0xFFFF.
REQ-038 Loopback CIPO=COPI, addr=0xA5, data=0x3C -> rx_data=0xA53C at done; busy low 4 cycles after done.
REQ-039 start held high for 3 frames -> 3 done pulses, CS low >=4 cycles between frames, and the extra starts during busy are ignored.
REQ-040 reset=0 during bit 7 XFER high phase -> next edge CS=0, SCK=0, busy=0, and done never pulses; the following frame addr=0x01, data=0x7F is correct.
REQ-041 address/data toggled every cycle while busy -> frame carries only the values latched at start.
REQ-042 CLK_DIV=2 -> SCK period 4 cycles, CS high 68 cycles, and rx_data is correct in loopback.
